// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receiver, 5-8 data bits, optional even parity, 1-2 stop bits.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote of samples around the bit centre.
module uart_receiver #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       two_stop_bits,
    input  logic [1:0] word_length,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = DIV_RAW < 1 ? 1 : DIV_RAW;
    localparam int DW      = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int SMP = OVERSAMPLE / 2 + 1;
`else
    localparam int SMP = OVERSAMPLE / 2;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
    state_t        state;
    logic          rx_s1, rx_s2, rx_d;
    logic [DW-1:0] div_cnt;
    logic [SW-1:0] s_cnt, s_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic          par, perr, par_en_l, two_l;
    logic [1:0]    wl_l;
    logic          tick, smp_now, bit_val, done;

    assign tick    = div_cnt == DW'(DIV - 1);
    assign s_nxt   = s_cnt + 1'b1;
    assign smp_now = tick && s_nxt == SW'(SMP);
    assign rx_busy = state != IDLE;
    assign done    = smp_now && (state == STOP2 || (state == STOP1 && !(two_l && bit_val)));

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) hist <= 2'b11;
        else if (tick) hist <= {hist[0], rx_s2};
    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s2) | (hist[0] & rx_s2);
`else
    assign bit_val = rx_s2;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_d       <= 1'b1;
            state      <= IDLE;
            div_cnt    <= '0;
            s_cnt      <= '0;
            bit_cnt    <= '0;
            sh         <= '0;
            par        <= 1'b0;
            perr       <= 1'b0;
            par_en_l   <= 1'b0;
            two_l      <= 1'b0;
            wl_l       <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_d       <= rx_s2;
            data_valid <= 1'b0;
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;
            if (state != IDLE && tick) s_cnt <= s_nxt == SW'(OVERSAMPLE) ? '0 : s_nxt;
            case (state)
                IDLE: if (rx_d && !rx_s2) begin
                    state    <= START;
                    div_cnt  <= '0;
                    s_cnt    <= '0;
                    bit_cnt  <= '0;
                    sh       <= '0;
                    par      <= 1'b0;
                    perr     <= 1'b0;
                    par_en_l <= parity_en;
                    two_l    <= two_stop_bits;
                    wl_l     <= word_length;
                end
                START:  if (smp_now) state <= bit_val ? IDLE : DATA;
                DATA: if (smp_now) begin
                    sh      <= {bit_val, sh[7:1]};
                    par     <= par ^ bit_val;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == {1'b1, wl_l}) state <= par_en_l ? PARITY : STOP1;
                end
                PARITY: if (smp_now) begin
                    perr  <= bit_val != par;
                    state <= STOP1;
                end
                STOP1:  if (smp_now) state <= two_l && bit_val ? STOP2 : IDLE;
                STOP2:  if (smp_now) state <= IDLE;
                default: state <= IDLE;
            endcase
            // Bits arrive LSB-first at sh[7], so short words sit high and are shifted down.
            if (done) begin
                data_out   <= sh >> (2'd3 - wl_l);
                parity_err <= perr;
                frame_err  <= !bit_val;
                data_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames against a frame-level reference model.
module tb_uart_receiver;
`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ = 1'b1;
`else
    localparam bit MAJ = 1'b0;
`endif
    logic       clk = 1'b0, rstn = 1'b0, rx = 1'b1, parity_en = 1'b0, two_stop_bits = 1'b0;
    logic [1:0] word_length = 2'b11;
    logic [7:0] data_out;
    logic       data_valid, parity_err, frame_err, rx_busy;
    int         checks = 0, passed = 0;
    int         cyc = 0, dv_cnt = 0, dv_cyc = 0, f_c0 = 0;

    uart_receiver #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16)) dut (
        .clk(clk), .rstn(rstn), .rx(rx), .parity_en(parity_en), .two_stop_bits(two_stop_bits),
        .word_length(word_length), .data_out(data_out), .data_valid(data_valid),
        .parity_err(parity_err), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (data_valid === 1'b1) begin
        dv_cnt <= dv_cnt + 1;
        dv_cyc <= cyc;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] d, input int nb, input logic pe, input logic pb, input logic two,
                        input logic s1, input logic s2, input int glitch, input int cut, input bit scramble);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pb);
        bits.push_back(s1);
        if (two) bits.push_back(s2);
        parity_en = pe;
        two_stop_bits = two;
        word_length = 2'(nb - 5);
        for (int c = 0; c < bits.size() * 16; c++) begin
            if (c == cut) return;
            @(negedge clk);
            rx = bits[c / 16] ^ (c == glitch);
            if (scramble && c == 40) {parity_en, two_stop_bits, word_length} = 4'($urandom);
        end
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input int nb, input logic pe, input logic pb,
                         input logic two, input logic s1, input logic s2, input int glitch, input bit scramble);
        logic [7:0] exp_d;
        int dv0;
        exp_d = d & 8'((1 << nb) - 1);
        if (glitch >= 0 && !MAJ) exp_d[glitch / 16 - 1] = ~exp_d[glitch / 16 - 1];
        idle(4);
        dv0 = dv_cnt;
        f_c0 = cyc;
        send(d, nb, pe, pb, two, s1, s2, glitch, -1, scramble);
        idle(24);
        check({tag, " pulses"}, dv_cnt - dv0, 1);
        check({tag, " data"}, data_out, exp_d);
        check({tag, " parity_err"}, parity_err, pe && (pb != ^exp_d));
        check({tag, " frame_err"}, frame_err, !s1 || (two && !s2));
        check({tag, " busy"}, rx_busy, 0);
    endtask

    initial begin
        int nb, k, dv0;
        logic [7:0] d, saved_d;
        logic pe, pb, two, s1, s2, saved_pe, saved_fe;
        repeat (3) @(negedge clk);
        check("reset data_out", data_out, 0);
        check("reset data_valid", data_valid, 0);
        check("reset parity_err", parity_err, 0);
        check("reset frame_err", frame_err, 0);
        check("reset rx_busy", rx_busy, 0);
        rstn = 1'b1;
        idle(8);

        frame("8N1 A5", 8'hA5, 8, 0, 0, 0, 1, 1, -1, 0);
        check("8N1 latency", (dv_cyc - f_c0) >= 153 && (dv_cyc - f_c0) <= 157, 1);

        frame("5E1 13 good", 8'h13, 5, 1, 1, 0, 1, 1, -1, 0);
        frame("5E1 13 bad", 8'h13, 5, 1, 0, 0, 1, 1, -1, 0);

        frame("8N2 3C stop2 low", 8'h3C, 8, 0, 0, 1, 1, 0, -1, 0);
        frame("8N2 55", 8'h55, 8, 0, 0, 1, 1, 1, -1, 0);

        idle(4);
        dv0 = dv_cnt;
        saved_d = data_out;
        saved_pe = parity_err;
        saved_fe = frame_err;
        repeat (4) begin
            @(negedge clk);
            rx = 1'b0;
        end
        @(negedge clk);
        rx = 1'b1;
        check("false start busy", rx_busy, 1);
        k = 0;
        while (rx_busy === 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
        end
        check("false start busy clears", k <= 9, 1);
        idle(12);
        check("false start pulses", dv_cnt - dv0, 0);
        check("false start data", data_out, saved_d);
        check("false start flags", {parity_err, frame_err}, {saved_pe, saved_fe});

        idle(4);
        dv0 = dv_cnt;
        send(8'hC3, 8, 0, 0, 0, 1, 1, -1, 70, 0);
        rstn = 1'b0;
        #1;
        check("abort data_out", data_out, 0);
        check("abort data_valid", data_valid, 0);
        check("abort flags", {parity_err, frame_err}, 0);
        check("abort rx_busy", rx_busy, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        idle(30);
        check("abort pulses", dv_cnt - dv0, 0);
        frame("after abort 81", 8'h81, 8, 0, 0, 0, 1, 1, -1, 0);

        frame("glitch FF", 8'hFF, 8, 0, 0, 0, 1, 1, 56, 0);

        for (int i = 0; i < 10; i++) begin
            nb  = 5 + int'($urandom_range(3));
            d   = 8'($urandom);
            pe  = 1'($urandom);
            pb  = 1'($urandom);
            two = 1'($urandom);
            s1  = $urandom_range(3) != 0;
            s2  = $urandom_range(3) != 0;
            frame("random", d, nb, pe, pb, two, s1, s2, -1, 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
